// File: rtl/ieee754_pkg.sv
// ieee754_pkg: shared single-precision field widths, NaN/zero helpers and the argmax FSM state type.
package ieee754_pkg;

   localparam int FP_W  = 32;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   localparam logic [EXP_W-1:0] EXP_NAN = 8'hFF;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic is_nan(input logic [FP_W-1:0] x);
      return x[FP_W-2 -: EXP_W] == EXP_NAN && x[MAN_W-1:0] != '0;
   endfunction

   // Both signed zeros have an all-zero magnitude field.
   function automatic logic is_zero(input logic [FP_W-1:0] x);
      return x[FP_W-2:0] == '0;
   endfunction

endpackage

// File: rtl/ieee754_compare.sv
// ieee754_compare: raw sign-magnitude greater-than of two single-precision words; NaN and signed zero are not special-cased here.
module ieee754_compare
   import ieee754_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic            gt
);

   logic mag_gt;
   logic mag_lt;

   assign mag_gt = a[FP_W-2:0] > b[FP_W-2:0];
   assign mag_lt = a[FP_W-2:0] < b[FP_W-2:0];

   // Differing signs: a wins only when it is the positive one; both negative reverses magnitude order.
   assign gt = a[FP_W-1] != b[FP_W-1] ? b[FP_W-1] : a[FP_W-1] ? mag_lt : mag_gt;

endmodule

// File: rtl/ieee754_argmax.sv
// ieee754_argmax: streams N single-precision elements and reports the largest value and its first arrival index.
module ieee754_argmax
   import ieee754_pkg::*;
#(
   parameter int N     = 10,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [FP_W-1:0]  in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             out_valid,
   output logic [FP_W-1:0]  max_value,
   output logic [IDX_W-1:0] max_index
);

   localparam logic [IDX_W-1:0] last_idx = IDX_W'(N - 1);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] cnt;
   logic             accept;
   logic             at_last;
   logic             gt;
   logic             replace;

   ieee754_compare u_cmp (
      .a  (in_data),
      .b  (max_value),
      .gt (gt)
   );

   assign accept  = in_valid && state == RUN;
   assign at_last = cnt == last_idx;

   // A NaN held from slot 0 yields to any real number; a NaN never displaces anything; +0 and -0 tie.
   assign replace = cnt == '0 ||
                    (!is_nan(in_data) && !(is_zero(in_data) && is_zero(max_value)) &&
                     (gt || is_nan(max_value)));

   always_comb begin
      state_nxt = state == IDLE ? (start ? RUN : IDLE)
                : state == RUN  ? (accept && at_last ? DONE : RUN)
                : IDLE;
      in_ready  = state == RUN;
      busy      = state != IDLE;
      out_valid = state == DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         max_value <= '0;
         max_index <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start)
            cnt <= '0;
         else if (accept && !at_last)
            cnt <= cnt + 1'b1;
         if (accept && replace) begin
            max_value <= in_data;
            max_index <= cnt;
         end
      end
   end

endmodule

// File: tb/tb_ieee754_argmax.sv
// tb_ieee754_argmax: randomized and directed checks of ieee754_argmax (N=4) against a real-valued reference model.
module tb_ieee754_argmax;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_ready;
   logic          busy;
   logic          out_valid;
   logic [31:0]   max_value;
   logic [IW-1:0] max_index;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] el [N];

   ieee754_argmax #(.N(N), .IDX_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .max_value (max_value),
      .max_index (max_index)
   );

   always #5 clk = ~clk;

   function automatic bit nan_of(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] != 23'h0;
   endfunction

   // Numeric value of a single-precision word; infinity maps beyond any finite single.
   function automatic real f2r(input logic [31:0] x);
      real m = real'(x[22:0]);
      real r;
      if (x[30:23] == 8'h00)
         r = m * 2.0 ** (-149.0);
      else if (x[30:23] == 8'hFF)
         r = 1.0e300;
      else
         r = (1.0 + m / 8388608.0) * 2.0 ** (real'(x[30:23]) - 127.0);
      return x[31] ? -r : r;
   endfunction

   function automatic void model(output logic [31:0] v, output logic [IW-1:0] idx);
      v   = el[0];
      idx = '0;
      for (int i = 1; i < N; i++)
         if (!nan_of(el[i]) && (nan_of(v) || f2r(el[i]) > f2r(v))) begin
            v   = el[i];
            idx = IW'(i);
         end
   endfunction

   function automatic logic [31:0] gen();
      logic        s = 1'($urandom);
      int          k = $urandom_range(0, 9);
      logic [22:0] m;
      if (k == 0) return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      if (k == 1) return {s, 31'h0};
      if (k == 2) return {s, 8'hFF, 23'h0};
      if (k == 3) return {s, 8'h00, 23'($urandom_range(1, 255))};
      m = $urandom_range(0, 2) == 0 ? 23'h0 : $urandom_range(0, 1) == 1 ? 23'h400000 : 23'($urandom);
      return {s, 8'(125 + $urandom_range(0, 4)), m};
   endfunction

   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Feeds el[] from the RUN state, returning the DONE-cycle outputs and handshake observations.
   task automatic run_search(input int maxgap, output logic [31:0] v, output logic [IW-1:0] idx,
                             output int pulses, output bit timing_ok, output bit ready_ok);
      pulses   = 0;
      ready_ok = 1'b1;
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(0, maxgap)) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            if (in_ready !== 1'b1 || busy !== 1'b1) ready_ok = 1'b0;
            pulses += int'(out_valid);
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = el[i];
         if (in_ready !== 1'b1 || busy !== 1'b1) ready_ok = 1'b0;
         pulses += int'(out_valid);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      timing_ok = out_valid === 1'b1;
      if (in_ready !== 1'b0 || busy !== 1'b1) ready_ok = 1'b0;
      pulses += int'(out_valid);
      v   = max_value;
      idx = max_index;
      @(negedge clk);
      pulses += int'(out_valid);
      if (in_ready !== 1'b0) ready_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 32'h3F800000;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 000", {out_valid, busy, in_ready});
      end
      checks++;
      if (max_value !== 32'h0 || max_index !== '0) begin
         errors++; $display("FAIL reset_data: got %h/%0d expected 00000000/0", max_value, max_index);
      end
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_idle: got busy=%b ready=%b expected 0 0", busy, in_ready);
      end
   endtask

   task automatic test_directed();
      logic [31:0]   vec [3][N] = '{'{32'h40400000, 32'h40480000, 32'hC0400000, 32'h3F800000},
                                    '{32'hC0480000, 32'hC0400000, 32'hC0400000, 32'hC0800000},
                                    '{32'h80000000, 32'h00000000, 32'h7FC00000, 32'hBF800000}};
      logic [31:0]   exp_v [3] = '{32'h40480000, 32'hC0400000, 32'h80000000};
      logic [IW-1:0] exp_i [3] = '{2'd1, 2'd1, 2'd0};
      logic [31:0]   v;
      logic [IW-1:0] idx;
      int            pulses;
      bit            t_ok, r_ok;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < N; i++) el[i] = vec[t][i];
         kick();
         run_search(0, v, idx, pulses, t_ok, r_ok);
         checks++;
         if (v !== exp_v[t] || idx !== exp_i[t]) begin
            errors++; $display("FAIL directed%0d: got %h/%0d expected %h/%0d", t, v, idx, exp_v[t], exp_i[t]);
         end
         checks++;
         if (!t_ok || pulses != 1 || !r_ok) begin
            errors++; $display("FAIL directed%0d_timing: got timing=%0d pulses=%0d ready=%0d expected 1 1 1", t, t_ok, pulses, r_ok);
         end
      end
   endtask

   task automatic test_gaps();
      logic [31:0]   v, hold_v;
      logic [IW-1:0] idx, hold_i;
      int            pulses;
      bit            t_ok, r_ok;
      el = '{32'h40400000, 32'h40480000, 32'hC0400000, 32'h3F800000};
      for (int r = 0; r < 4; r++) begin
         kick();
         run_search(4, v, idx, pulses, t_ok, r_ok);
         checks++;
         if (v !== 32'h40480000 || idx !== 2'd1) begin
            errors++; $display("FAIL gaps_result: got %h/%0d expected 40480000/1", v, idx);
         end
         checks++;
         if (!t_ok || pulses != 1 || !r_ok) begin
            errors++; $display("FAIL gaps_handshake: got timing=%0d pulses=%0d ready=%0d expected 1 1 1", t_ok, pulses, r_ok);
         end
      end
      hold_v = max_value; hold_i = max_index;
      repeat (5) begin
         in_valid = 1'($urandom); in_data = 32'h7F000000;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (max_value !== 32'h40480000 || max_index !== 2'd1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL gaps_hold: got %h/%0d ready=%b expected 40480000/1 ready=0", max_value, max_index, in_ready);
      end
   endtask

   task automatic test_midreset();
      logic [31:0]   v, ev;
      logic [IW-1:0] idx, ei;
      int            pulses = 0;
      bit            t_ok, r_ok;
      el = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
      kick();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = el[i];
         @(negedge clk);
      end
      rst = 1'b1; start = 1'b1; in_data = el[2];
      @(negedge clk);
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b000 || max_value !== 32'h0 || max_index !== '0) begin
         errors++; $display("FAIL midreset_state: got ctrl=%b %h/%0d expected 000 00000000/0", {out_valid, busy, in_ready}, max_value, max_index);
      end
      repeat (4) begin
         pulses += int'(out_valid);
         @(negedge clk);
      end
      checks++;
      if (pulses != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_quiet: got pulses=%0d busy=%b expected 0 0", pulses, busy);
      end
      el = '{32'hC1000000, 32'h00000000, 32'h7F800000, 32'h41000000};
      model(ev, ei);
      kick();
      run_search(1, v, idx, pulses, t_ok, r_ok);
      checks++;
      if (v !== ev || idx !== ei || pulses != 1) begin
         errors++; $display("FAIL midreset_fresh: got %h/%0d pulses=%0d expected %h/%0d pulses=1", v, idx, pulses, ev, ei);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0]   v, ev;
      logic [IW-1:0] idx, ei;
      int            pulses;
      bit            t_ok, r_ok;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < N; i++) el[i] = gen();
         model(ev, ei);
         run_search(2, v, idx, pulses, t_ok, r_ok);
         checks++;
         if (v !== ev || idx !== ei) begin
            errors++; $display("FAIL b2b%0d_result: got %h/%0d expected %h/%0d", s, v, idx, ev, ei);
         end
         checks++;
         if (busy !== 1'b0 || pulses != 1 || !t_ok || !r_ok) begin
            errors++; $display("FAIL b2b%0d_ctrl: got busy=%b pulses=%0d timing=%0d ready=%0d expected 0 1 1 1", s, busy, pulses, t_ok, r_ok);
         end
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b%0d_restart: got busy=%b ready=%b expected 1 1", s, busy, in_ready);
         end
      end
      start = 1'b0;
      for (int i = 0; i < N; i++) el[i] = gen();
      model(ev, ei);
      run_search(0, v, idx, pulses, t_ok, r_ok);
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || v !== ev || idx !== ei) begin
         errors++; $display("FAIL b2b_release: got busy=%b %h/%0d expected 0 %h/%0d", busy, v, idx, ev, ei);
      end
   endtask

   task automatic test_random();
      logic [31:0]   v, ev;
      logic [IW-1:0] idx, ei;
      int            pulses;
      bit            t_ok, r_ok;
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < N; i++) el[i] = gen();
         model(ev, ei);
         kick();
         run_search(2, v, idx, pulses, t_ok, r_ok);
         checks++;
         if (v !== ev || idx !== ei || pulses != 1 || !t_ok) begin
            errors++;
            $display("FAIL random%0d: got %h/%0d pulses=%0d timing=%0d expected %h/%0d pulses=1 timing=1 (in %h %h %h %h)",
                     t, v, idx, pulses, t_ok, ev, ei, el[0], el[1], el[2], el[3]);
         end
      end
   endtask

   initial begin
      start = 1'b0; in_valid = 1'b0; in_data = '0; rst = 1'b0;
      test_reset();
      test_directed();
      test_gaps();
      test_midreset();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ieee754_argmax.md
IEEE754_ARGMAX -- requirements
Module: ieee754_argmax

Interface
REQ-001 Parameter N, default 10: number of IEEE-754 single-precision elements per search, N >= 2.
REQ-002 Parameter IDX_W, default 4: index width, equal to clog2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begins a new search; sampled only in IDLE.
REQ-006 in_valid  input  1  in_data holds an element.
REQ-007 in_data  input  32  IEEE-754 single-precision element.
REQ-008 in_ready  output  1  block can accept an element this cycle.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 out_valid  output  1  one-cycle pulse when the result is valid.
REQ-011 max_value  output  32  largest element of the completed search.
REQ-012 max_index  output  IDX_W  arrival position of max_value, 0-based.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE on the cycle the N-th element is accepted.
- DONE -> IDLE unconditionally after one cycle.
REQ-014 An element SHALL be accepted on a rising edge with in_valid && in_ready; in_ready SHALL be high only in RUN.
REQ-015 On IDLE -> RUN, the element counter SHALL clear to 0.
REQ-016 The counter SHALL increment by 1 per accepted element; it SHALL never exceed N-1 and SHALL not wrap within a search.
REQ-017 The element accepted at count 0 SHALL load max_value and max_index=0 unconditionally.
REQ-018 A later element SHALL replace max_value and max_index (index = counter) only when it is strictly greater than the current max_value, as decided by the comparator.
- Ties SHALL keep the earliest index.
REQ-019 +0 (0x00000000) and -0 (0x80000000) SHALL compare equal, so neither replaces the other.
REQ-020 A NaN element (exp=0xFF, mantissa != 0) at count > 0 SHALL never replace the max.
- A NaN at count 0 SHALL be loaded, and SHALL be replaced by the next non-NaN element.
REQ-021 Timing and holding of the result:
- out_valid SHALL be high exactly during the DONE cycle, i.e. one cycle after the N-th accept.
- max_value and max_index SHALL hold their values from then until the next search accepts its first element.
REQ-022 start asserted in RUN or DONE SHALL be ignored and SHALL not be queued.
REQ-023 Gaps in in_valid during RUN SHALL stall the search indefinitely, with no timeout.
REQ-024 There SHALL be no combinational path from in_data to any output.

Reset
REQ-025 With rst high at a rising edge:
- state = IDLE, counter = 0.
- out_valid = 0, busy = 0, in_ready = 0.
- max_value = 0x00000000, max_index = 0.
REQ-026 Reset mid-search SHALL abandon the search with no out_valid pulse; rst SHALL take priority over start and in_valid in the same cycle.

Structure
REQ-027 A shared package ieee754_pkg SHALL hold:
- FP_W=32, EXP_W=8, MAN_W=23.
- The NaN-detect constant exponent 0xFF.
- The state enum {IDLE, RUN, DONE}.
REQ-028 The block SHALL instantiate one existing ieee754_compare (A = incoming element, B = current max, result = A > B).
REQ-029 The NaN and signed-zero qualification SHALL be applied outside the comparator.
REQ-030 No other sub-modules SHALL be used.

Verification
REQ-031 Ascending input, N=4: start; 3.0 (0x40400000), 3.125 (0x40480000), -3.0 (0xC0400000), 1.0 (0x3F800000) -> out_valid one cycle after 4th accept; max_value=0x40480000, max_index=1.
REQ-032 All-negative with tie, N=4: -3.125, -3.0, -3.0, -4.0 -> max_value=0xC0400000, max_index=1 (earliest tie kept).
REQ-033 Signed zero and NaN, N=4: -0, +0, 0x7FC00000, -1.0 -> max_value=0x80000000, max_index=0.
REQ-034 in_valid gaps, N=4: random idle cycles between elements -> same result as the gap-free run; out_valid exactly once; in_ready low outside RUN.
REQ-035 Reset after 2 of 4 elements -> no out_valid, outputs at reset values; a fresh search then completes correctly.
REQ-036 start held high through RUN and DONE -> exactly one search per IDLE entry; back-to-back searches give independent results.
